// File: rtl/debug_latch_dumper.sv
// Snapshots the four pipeline latch buses on request and streams them bytewise to a UART TX.
// Optional trailing XOR checksum byte: define DEBUG_DUMP_CHECKSUM_EN.
module debug_latch_dumper #(
  parameter int              NB_IF_ID  = 64,
  parameter int              NB_ID_EX  = 192,
  parameter int              NB_EX_MEM = 128,
  parameter int              NB_MEM_WB = 64,
  parameter int              NB_DATA   = 8,
  parameter logic [NB_DATA-1:0] HEADER = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NB_IF_ID-1:0]  i_if_id,
  input  logic [NB_ID_EX-1:0]  i_id_ex,
  input  logic [NB_EX_MEM-1:0] i_ex_mem,
  input  logic [NB_MEM_WB-1:0] i_mem_wb,
  input  logic                 i_dump_req,
  input  logic                 i_tx_done,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_dump_done
);

  localparam int NB_SNAP = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
  localparam int N_DATA  = NB_SNAP / 8;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int N_FRAME = N_DATA + 2;
`else
  localparam int N_FRAME = N_DATA + 1;
`endif
  localparam int CW = $clog2(N_FRAME + 1);
  localparam int IW = $clog2(N_DATA);

  localparam logic [CW-1:0] DATA_END = CW'(N_DATA);
  localparam logic [CW-1:0] LAST     = CW'(N_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NB_SNAP-1:0] snap;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      didx;
  logic [NB_DATA-1:0] tx_byte;
  logic [NB_DATA-1:0] bytes [N_DATA];

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [NB_DATA-1:0] csum;
`endif

  // bytes[0] is the most significant byte of the snapshot
  for (genvar g = 0; g < N_DATA; g++) begin : g_bytes
    assign bytes[g] = snap[NB_SNAP-1-NB_DATA*g -: NB_DATA];
  end

  assign didx = IW'(cnt - CW'(1));

  always_comb begin
    tx_byte = '0;
    if (cnt == '0) begin
      tx_byte = HEADER;
    end else if (cnt <= DATA_END) begin
      tx_byte = bytes[didx];
`ifdef DEBUG_DUMP_CHECKSUM_EN
    end else if (cnt == LAST) begin
      tx_byte = csum;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_dump_req) state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          state_nxt = (cnt == LAST) ? DONE : SEND;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      snap  <= '0;
      cnt   <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_dump_req) begin
        snap <= {i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
        cnt  <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum <= '0;
`endif
      end else if (state == WAIT && i_tx_done) begin
        cnt  <= cnt + CW'(1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
        csum <= csum ^ tx_byte;
`endif
      end
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_tx_start  = (state == SEND);
  assign o_dump_done = (state == DONE);
  assign o_tx_data   = (state == IDLE) ? '0 : tx_byte;

endmodule
